// File: rtl/demux2_sched.sv
// Job scheduler that steers one valid/ready stream to lane A or lane B through a single
// output register, with fixed or burst-alternating routing and a done pulse per job.
module demux2_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [CNT_W-1:0]      cfg_burst_i,
  input  logic [CNT_W-1:0]      cfg_total_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sel_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] a_data_o,
  output logic                  a_valid_o,
  input  logic                  a_ready_i,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a word moves on any edge where valid and ready are both high; a held
  // word and its data stay unchanged until its own lane's ready is seen high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_alt;
  logic [CNT_W-1:0]      r_burst;
  logic [CNT_W-1:0]      r_total;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_bcnt;
  logic                  r_sel;
  logic                  r_full;
  logic                  r_tag;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_consume;
  logic w_in_ready;
  logic w_accept;
  logic w_last;
  logic w_burst_end;

  assign w_consume   = r_full && (r_tag ? a_ready_i : b_ready_i);
  assign w_in_ready  = (r_state == S_RUN) && (!r_full || w_consume);
  assign w_accept    = w_in_ready && in_valid_i;
  assign w_last      = (r_cnt + CNT_W'(1)) == r_total;
  assign w_burst_end = (r_bcnt + CNT_W'(1)) == r_burst;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_alt   <= 1'b0;
      r_burst <= '0;
      r_total <= '0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_sel   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_alt   <= cfg_mode_i[1];
            // A zero burst length behaves as a burst of one word.
            r_burst <= (cfg_burst_i == '0) ? CNT_W'(1) : cfg_burst_i;
            r_total <= cfg_total_i;
            r_cnt   <= '0;
            r_bcnt  <= '0;
            r_sel   <= (cfg_mode_i != 2'b01);
            r_state <= (cfg_total_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= S_DRAIN;
            if (r_alt) begin
              if (w_burst_end) begin
                r_bcnt <= '0;
                r_sel  <= ~r_sel;
              end else begin
                r_bcnt <= r_bcnt + CNT_W'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (!r_full || w_consume) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: loads a tagged word on accept, empties when its lane takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full <= 1'b0;
      r_tag  <= 1'b1;
      r_data <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_tag  <= r_sel;
      r_data <= in_data_i;
    end else if (w_consume) begin
      r_full <= 1'b0;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign sel_o       = r_sel;
  assign a_valid_o   = r_full && r_tag;
  assign b_valid_o   = r_full && !r_tag;
  assign a_data_o    = a_valid_o ? r_data : '0;
  assign b_data_o    = b_valid_o ? r_data : '0;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_demux2_sched.sv
// Bench for demux2_sched: table of fixed jobs, hand-written corner sequences and random
// jobs, all scored against expected-word queues filled from a routing model.
module tb_demux2_sched;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] burst;
  logic [CW-1:0] total;
  logic          busy_o, done_o, sel_o;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready_o;
  logic [DW-1:0] a_data_o, b_data_o;
  logic          a_valid_o, b_valid_o;
  logic          a_ready, b_ready;
  logic [1:0]    dbg_state_o;

  demux2_sched #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_mode_i(mode),
    .cfg_burst_i(burst), .cfg_total_i(total), .busy_o(busy_o), .done_o(done_o),
    .sel_o(sel_o), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .a_data_o(a_data_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready),
    .b_data_o(b_data_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int          burst;
    int          total;
    logic [15:0] mask;   // bit i set: word i goes to lane A
    int          lat;    // edges after the start edge until done_o is seen
  } vec_t;

  vec_t tab[8];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  int            m_mode, m_burst, m_total, m_acc, m_base;
  bit            use_tab;
  logic [15:0]   tab_mask;
  int            done_cnt = 0;
  int            ir_cnt, av_cnt;
  bit            prev_a_stall, prev_b_stall;
  logic [DW-1:0] prev_a_data, prev_b_data;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference routing: which lane word idx of the job belongs to.
  function automatic bit model_route_a(input int idx);
    int beff;
    if (m_mode == 0) return 1'b1;
    if (m_mode == 1) return 1'b0;
    beff = (m_burst == 0) ? 1 : m_burst;
    return ((idx / beff) % 2) == 0;
  endfunction

  // scoreboard, called once per cycle at the falling edge
  task automatic sample();
    logic [DW-1:0] e;
    bit            r;
    if (rst) begin
      prev_a_stall = 1'b0;
      prev_b_stall = 1'b0;
      return;
    end
    if (in_ready_o) ir_cnt++;
    if (a_valid_o) av_cnt++;
    if (in_valid && in_ready_o) begin
      r = use_tab ? tab_mask[m_acc[3:0]] : model_route_a(m_acc);
      check("overrun", int'(m_acc < m_total), 1);
      check("sel", int'(sel_o), int'(r));
      if (r) exp_a_q.push_back(in_data);
      else   exp_b_q.push_back(in_data);
      m_acc++;
    end
    if (prev_a_stall) begin
      check("a_hold_valid", int'(a_valid_o), 1);
      check("a_hold_data", int'(a_data_o), int'(prev_a_data));
    end
    if (prev_b_stall) begin
      check("b_hold_valid", int'(b_valid_o), 1);
      check("b_hold_data", int'(b_data_o), int'(prev_b_data));
    end
    if (a_valid_o && a_ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected", 1, 0);
      else begin
        e = exp_a_q.pop_front();
        check("a_data", int'(a_data_o), int'(e));
      end
    end else if (!a_valid_o) check("a_idle_zero", int'(a_data_o), 0);
    if (b_valid_o && b_ready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
      else begin
        e = exp_b_q.pop_front();
        check("b_data", int'(b_data_o), int'(e));
      end
    end else if (!b_valid_o) check("b_idle_zero", int'(b_data_o), 0);
    prev_a_stall = a_valid_o && !a_ready;
    prev_b_stall = b_valid_o && !b_ready;
    prev_a_data  = a_data_o;
    prev_b_data  = b_data_o;
    if (done_o) done_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_sel", int'(sel_o), 1);
    check("rst_in_ready", int'(in_ready_o), 0);
    check("rst_a_valid", int'(a_valid_o), 0);
    check("rst_b_valid", int'(b_valid_o), 0);
    check("rst_a_data", int'(a_data_o), 0);
    check("rst_b_data", int'(b_data_o), 0);
    check("rst_state", int'(dbg_state_o), 0);
  endtask

  // driver tasks
  task automatic begin_job(input int md, input int bu, input int tot, input bit tb_tab,
                           input logic [15:0] mk, input int base);
    m_mode = md; m_burst = bu; m_total = tot; m_acc = 0; m_base = base;
    use_tab = tb_tab; tab_mask = mk; ir_cnt = 0; av_cnt = 0;
    exp_a_q.delete(); exp_b_q.delete();
    mode = md[1:0]; burst = bu[CW-1:0]; total = tot[CW-1:0];
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom_range(3)); burst = CW'($urandom); total = CW'($urandom);
  endtask

  task automatic drive_until_done(input int vpct, input int rpct, output int lat);
    lat = -1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_valid = ($urandom_range(99) < vpct);
      in_data  = DW'(m_base + m_acc);
      a_ready  = ($urandom_range(99) < rpct);
      b_ready  = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (cyc == 0) check("busy_start", int'(busy_o), 1);
      sample();
      if (done_o) lat = cyc;
      @(posedge clk);
      #1;
      if (lat >= 0) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic post_checks(input int d0);
    check("done_seen_once", done_cnt - d0, 1);
    check("words_accepted", m_acc, m_total);
    check("a_leftover", exp_a_q.size(), 0);
    check("b_leftover", exp_b_q.size(), 0);
    @(negedge clk);
    check("done_after", int'(done_o), 0);
    check("busy_after", int'(busy_o), 0);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int md, input int bu, input int tot, input bit tb_tab,
                         input logic [15:0] mk, input int base, input int vpct,
                         input int rpct, input int exp_lat);
    int d0;
    int lat;
    d0 = done_cnt;
    begin_job(md, bu, tot, tb_tab, mk, base);
    drive_until_done(vpct, rpct, lat);
    check("done_timeout", int'(lat >= 0), 1);
    if (exp_lat >= 0) begin
      check("latency", lat, exp_lat);
      check("in_ready_cycles", ir_cnt, tot);
      check("a_valid_cycles", av_cnt, $countones(mk));
    end
    post_checks(d0);
  endtask

  initial begin
    int lat;
    int d0;
    tab[0] = '{2'd0, 0, 4, 16'h000F, 5};
    tab[1] = '{2'd2, 2, 6, 16'h0033, 7};
    tab[2] = '{2'd1, 3, 3, 16'h0000, 4};
    tab[3] = '{2'd3, 1, 5, 16'h0015, 6};
    tab[4] = '{2'd2, 0, 4, 16'h0005, 5};
    tab[5] = '{2'd2, 3, 7, 16'h0047, 8};
    tab[6] = '{2'd0, 0, 0, 16'h0000, 0};
    tab[7] = '{2'd2, 5, 1, 16'h0001, 2};

    rst = 1'b0; start = 1'b0; mode = '0; burst = '0; total = '0;
    in_data = '0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // table of fixed jobs under continuous valid/ready
    for (int i = 0; i < 8; i++)
      run_job(int'(tab[i].mode), tab[i].burst, tab[i].total, 1'b1, tab[i].mask,
              1 + 16 * i, 100, 100, tab[i].lat);

    // lane A stalls for three cycles while holding word 1
    d0 = done_cnt;
    begin_job(0, 0, 3, 1'b1, 16'h0007, 1);
    in_valid = 1'b1; in_data = 16'd1; a_ready = 1'b1; b_ready = 1'b1;
    tick();
    in_data = 16'd2; a_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready_o), 0);
      check("stall_a_data", int'(a_data_o), 1);
      sample();
      @(posedge clk);
      #1;
    end
    drive_until_done(100, 100, lat);
    check("stall_done_timeout", int'(lat >= 0), 1);
    post_checks(d0);

    // a second start during a running job is ignored
    d0 = done_cnt;
    begin_job(0, 0, 4, 1'b0, 16'h0000, 50);
    in_valid = 1'b1; in_data = 16'd50; a_ready = 1'b1; b_ready = 1'b1;
    tick();
    in_data = 16'd51; start = 1'b1; mode = 2'b01; total = 8'd2;
    tick();
    start = 1'b0;
    drive_until_done(100, 100, lat);
    check("restart_done_timeout", int'(lat >= 0), 1);
    post_checks(d0);

    // reset in the middle of a five-word job
    begin_job(0, 0, 5, 1'b0, 16'h0000, 70);
    in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    in_data = 16'd70; tick();
    in_data = 16'd71; tick();
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1 check_reset_values();
    exp_a_q.delete(); exp_b_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle_busy", int'(busy_o), 0);
    run_job(1, 0, 2, 1'b1, 16'h0000, 90, 100, 100, 3);

    // random jobs scored against the routing model
    for (int j = 0; j < 40; j++)
      run_job(int'($urandom_range(3)), int'($urandom_range(4)), int'($urandom_range(20)),
              1'b0, 16'h0000, int'($urandom_range(40000)), int'($urandom_range(100, 40)),
              int'($urandom_range(100, 30)), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
